// File: rtl/adc78h90_spi_responder_if.sv
// SPI pin bundle between the ADC master and the ADC78H90 emulator.
`timescale 1ns/1ps
interface adc78h90_spi_responder_if;
    logic SCLK;
    logic nCS;
    logic MOSI;
    logic MISO;
    logic miso_oe;

    modport master (output SCLK, output nCS, output MOSI, input MISO, input miso_oe);
    modport slave  (input SCLK, input nCS, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/adc78h90_spi_responder.sv
// ADC78H90 emulator: 16-bit SPI target returning fabric channel values.
// Each frame returns the channel picked by the previous frame's control word.
`timescale 1ns/1ps
module adc78h90_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_CH    = 3'd0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    adc78h90_spi_responder_if.slave      spi,
    input  logic [95:0]                  ain_data,
    output logic [15:0]                  ctrl_word,
    output logic [2:0]                   next_ch,
    output logic                         frame_done,
    output logic                         frame_abort
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_WAIT} state_t;

    // synchronizer chains; the newest sample enters at bit 0
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q,  ncs_prev_d;

    logic sclk_s, ncs_s, mosi_s;
    logic rise, fall, csf, csr;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [14:0] sh_in_q, sh_in_d;      // bits already captured; the live MOSI bit completes the word
    logic [15:0] sh_out_q, sh_out_d;    // MISO is always the top bit
    logic        miso_oe_q, miso_oe_d;
    logic [15:0] ctrl_word_q, ctrl_word_d;
    logic [2:0]  next_ch_q, next_ch_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_abort_q, frame_abort_d;

    logic [11:0] ain_sel;
    logic [15:0] word;

    // shift the pins into the synchronizers and keep the previous synced level for edge detect
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.nCS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        ncs_prev_d  = ncs_sync_q[SYNC_STAGES-1];
    end

    // synchronizer registers; idle bus is SCLK low, nCS high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign rise   =  sclk_s & ~sclk_prev_q;
    assign fall   = ~sclk_s &  sclk_prev_q;
    assign csf    = ~ncs_s  &  ncs_prev_q;
    assign csr    =  ncs_s  & ~ncs_prev_q;

    // channel mux and the word as it would stand if this rise completed it
    always_comb begin
        ain_sel = ain_data[11:0];
        for (int k = 1; k < 8; k++) begin
            if (next_ch_q == 3'(k)) ain_sel = ain_data[12*k +: 12];
        end
        word = {sh_in_q, mosi_s};
    end

    // frame FSM: load on select, shift in on rise, shift out on fall
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sh_in_d       = sh_in_q;
        sh_out_d      = sh_out_q;
        miso_oe_d     = miso_oe_q;
        ctrl_word_d   = ctrl_word_q;
        next_ch_d     = next_ch_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_oe_d = 1'b0;
                if (csf) begin
                    sh_out_d  = {4'b0, ain_sel};
                    miso_oe_d = 1'b1;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                    // a rise coincident with select is the first data bit
                    if (rise) begin
                        sh_in_d   = word[14:0];
                        bit_cnt_d = 5'd1;
                    end
                end
            end
            ST_SHIFT: begin
                if (csr) begin
                    frame_abort_d = (bit_cnt_q != 5'd0);
                    miso_oe_d     = 1'b0;
                    sh_out_d      = '0;
                    bit_cnt_d     = 5'd0;
                    state_d       = ST_IDLE;
                end else if (rise) begin
                    sh_in_d   = word[14:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd15) begin
                        ctrl_word_d  = word;
                        next_ch_d    = word[13:11];
                        frame_done_d = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end else if (fall) begin
                    sh_out_d = {sh_out_q[14:0], 1'b0};
                end
            end
            ST_WAIT: begin
                if (csr) begin
                    miso_oe_d = 1'b0;
                    sh_out_d  = '0;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_IDLE;
                end else if (fall) begin
                    sh_out_d = '0;
                end else if (rise) begin
                    // continuous mode: next_ch already holds the channel just captured
                    sh_out_d  = {4'b0, ain_sel};
                    sh_in_d   = word[14:0];
                    bit_cnt_d = 5'd1;
                    state_d   = ST_SHIFT;
                end
            end
            default: begin
                miso_oe_d = 1'b0;
                sh_out_d  = '0;
                bit_cnt_d = 5'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // frame state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 5'd0;
            sh_in_q       <= '0;
            sh_out_q      <= '0;
            miso_oe_q     <= 1'b0;
            ctrl_word_q   <= '0;
            next_ch_q     <= RESET_CH;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sh_in_q       <= sh_in_d;
            sh_out_q      <= sh_out_d;
            miso_oe_q     <= miso_oe_d;
            ctrl_word_q   <= ctrl_word_d;
            next_ch_q     <= next_ch_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign spi.MISO    = sh_out_q[15];
    assign spi.miso_oe = miso_oe_q;
    assign ctrl_word   = ctrl_word_q;
    assign next_ch     = next_ch_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_adc78h90_spi_responder.sv
// Directed bench for the ADC78H90 emulator: plays the SPI master with
// SCLK at clock/16 and checks returned frames, control capture and pulses.
`timescale 1ns/1ps
module tb_adc78h90_spi_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [95:0] ain_data;
    logic [15:0] ctrl_word;
    logic [2:0]  next_ch;
    logic        frame_done, frame_abort;

    adc78h90_spi_responder_if spi ();

    adc78h90_spi_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .spi         (spi.slave),
        .ain_data    (ain_data),
        .ctrl_word   (ctrl_word),
        .next_ch     (next_ch),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0, abort_cnt = 0, both_cnt = 0;
    int d0, a0;
    logic [15:0] rx_w;

    // pulse counters, sampled away from the active edge
    always @(negedge clock) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (frame_done && frame_abort) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_ch(input int k, input logic [11:0] v);
        ain_data[12*k +: 12] = v;
    endtask

    // bits lo..hi-1 of w, MSB first; MISO sampled just before each rise
    task automatic spi_bits(input logic [15:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            spi.MOSI = w[15-i];
            clks(8);
            rx_w[15-i] = spi.MISO;
            spi.SCLK = 1'b1;
            clks(8);
            spi.SCLK = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi.nCS = 1'b0;
        clks(4);
    endtask

    task automatic cs_high();
        clks(4);
        spi.nCS = 1'b1;
        clks(6);
    endtask

    task automatic frame(input logic [15:0] w);
        rx_w = '0;
        cs_low();
        spi_bits(w, 0, 16);
        cs_high();
    endtask

    initial begin
        reset_n  = 1'b0;
        spi.SCLK = 1'b0;
        spi.nCS  = 1'b1;
        spi.MOSI = 1'b0;
        ain_data = '0;
        clks(3);
        chk("rst_miso", 32'(spi.MISO), 32'h0);
        chk("rst_oe", 32'(spi.miso_oe), 32'h0);
        chk("rst_ctrl", 32'(ctrl_word), 32'h0);
        chk("rst_next_ch", 32'(next_ch), 32'h0);
        chk("rst_pulses", 32'({frame_done, frame_abort}), 32'h0);
        reset_n = 1'b1;
        clks(4);

        // 1: ch0 returned, control 0800 selects ch1
        set_ch(0, 12'hABC);
        d0 = done_cnt;
        rx_w = '0;
        cs_low();
        chk("t1_oe_active", 32'(spi.miso_oe), 32'h1);
        spi_bits(16'h0800, 0, 16);
        cs_high();
        chk("t1_rx", 32'(rx_w), 32'h0ABC);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'h1);
        chk("t1_next_ch", 32'(next_ch), 32'h1);
        chk("t1_ctrl", 32'(ctrl_word), 32'h0800);
        chk("t1_oe_idle", 32'(spi.miso_oe), 32'h0);

        // 2: consecutive frames follow the pipelined channel select
        set_ch(1, 12'h123);
        set_ch(2, 12'hFFF);
        frame(16'h1000);
        chk("t2_rx_ch1", 32'(rx_w), 32'h0123);
        chk("t2_next_ch2", 32'(next_ch), 32'h2);
        frame(16'h0000);
        chk("t2_rx_ch2", 32'(rx_w), 32'h0FFF);
        chk("t2_next_ch0", 32'(next_ch), 32'h0);

        // 3: abort after 9 bits keeps the old channel
        set_ch(5, 12'h777);
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_low();
        spi_bits(16'h2800, 0, 9);
        cs_high();
        chk("t3_abort_cnt", 32'(abort_cnt - a0), 32'h1);
        chk("t3_no_done", 32'(done_cnt - d0), 32'h0);
        chk("t3_next_ch", 32'(next_ch), 32'h0);
        chk("t3_ctrl", 32'(ctrl_word), 32'h0000);
        frame(16'h0000);
        chk("t3_rx_old_ch", 32'(rx_w), 32'h0ABC);

        // 4: continuous mode, 32 SCLKs under one select
        set_ch(3, 12'h5A5);
        d0 = done_cnt;
        rx_w = '0;
        cs_low();
        spi_bits(16'h1800, 0, 16);
        chk("t4_rx_first", 32'(rx_w), 32'h0ABC);
        rx_w = '0;
        spi_bits(16'h0000, 0, 16);
        cs_high();
        chk("t4_rx_second", 32'(rx_w), 32'h05A5);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'h2);
        chk("t4_next_ch", 32'(next_ch), 32'h0);

        // 5: channel value frozen at load
        set_ch(0, 12'h000);
        rx_w = '0;
        cs_low();
        spi_bits(16'h2000, 0, 5);
        set_ch(0, 12'hFFF);
        spi_bits(16'h2000, 5, 16);
        cs_high();
        chk("t5_rx_frozen", 32'(rx_w), 32'h0000);
        chk("t5_next_ch", 32'(next_ch), 32'h4);

        // 6: reset mid-frame releases MISO at once, then a clean frame
        set_ch(4, 12'hFFF);
        rx_w = '0;
        cs_low();
        spi_bits(16'h0800, 0, 7);
        chk("t6_miso_pre", 32'(spi.MISO), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_miso_rst", 32'(spi.MISO), 32'h0);
        chk("t6_oe_rst", 32'(spi.miso_oe), 32'h0);
        chk("t6_next_ch_rst", 32'(next_ch), 32'h0);
        chk("t6_ctrl_rst", 32'(ctrl_word), 32'h0);
        spi.nCS = 1'b1;
        clks(3);
        reset_n = 1'b1;
        clks(4);
        d0 = done_cnt;
        frame(16'h0800);
        chk("t6_rx_after", 32'(rx_w), 32'h0FFF);
        chk("t6_next_ch", 32'(next_ch), 32'h1);
        chk("t6_done_cnt", 32'(done_cnt - d0), 32'h1);

        chk("never_both", 32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
